// File: rtl/z_decoder_if.sv
// z_decoder_if: code-word input and decoded/status outputs of z_decoder.
interface z_decoder_if;
  logic [3:0] Z;
  logic       valid;
  logic       X;
  logic       Y;
  logic       out_valid;
  logic       code_err;
  logic       locked;
  logic [7:0] err_count;
  modport master (output Z, valid, input X, Y, out_valid, code_err, locked, err_count);
  modport slave  (input Z, valid, output X, Y, out_valid, code_err, locked, err_count);
endinterface

// File: rtl/z_decoder.sv
// z_decoder: 4b->2b code decoder with HUNT/LOCKED framing FSM and saturating error count.
module z_decoder #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2
) (
  input logic        clk,
  input logic        reset,
  z_decoder_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] UC = 4'(UNLOCK_ERRS);
  state_t     state_q, state_d;
  logic [3:0] good_q, good_d, bad_q, bad_d;
  logic       x_q, x_d, y_q, y_d, ov_q, ov_d, ce_q, ce_d;
  logic [7:0] err_q, err_d;
  logic       legal;
  logic [1:0] dec;
  always_comb begin
    legal = 1'b1;
    dec   = 2'b00;
    case (bus.Z)
      4'b0000: dec = 2'b00;
      4'b0011: dec = 2'b01;
      4'b0110: dec = 2'b10;
      4'b1001: dec = 2'b11;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    ce_d    = 1'b0;
    if (bus.valid && legal) begin
      {x_d, y_d} = dec;
      if (state_q == HUNT) begin
        state_d = (good_q + 4'd1 == LC) ? LOCKED : HUNT;
        good_d  = (good_q + 4'd1 == LC) ? 4'd0 : good_q + 4'd1;
      end else begin
        bad_d = 4'd0;
      end
      ov_d = (state_d == LOCKED);
    end else if (bus.valid) begin
      ce_d  = 1'b1;
      err_d = (err_q == 8'hff) ? err_q : err_q + 8'd1;
      if (state_q == HUNT) begin
        good_d = 4'd0;
      end else begin
        // Unlock clears both runs so the next hunt starts from scratch
        state_d = (bad_q + 4'd1 == UC) ? HUNT : LOCKED;
        bad_d   = (bad_q + 4'd1 == UC) ? 4'd0 : bad_q + 4'd1;
        good_d  = 4'd0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      ov_q    <= 1'b0;
      ce_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      ce_q    <= ce_d;
      err_q   <= err_d;
    end
  end
  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.out_valid = ov_q;
  assign bus.code_err  = ce_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_z_decoder.sv
// tb_z_decoder: random and directed stimulus checked every cycle against a behavioural model.
module tb_z_decoder;
  localparam int LC = 4;
  localparam int UC = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int codes [4] = '{0, 3, 6, 9};
  z_decoder_if bus ();
  z_decoder #(.LOCK_COUNT(LC), .UNLOCK_ERRS(UC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    int good;
    int bad;
    bit x;
    bit y;
    bit ov;
    bit ce;
    int errs;
  } m_t;
  m_t m = '{default: 0};

  function automatic int decode(input logic [3:0] z);
    for (int i = 0; i < 4; i++) if (z == 4'(codes[i])) return i;
    return -1;
  endfunction

  function automatic m_t nxt(input m_t c, input logic [3:0] z, input logic v);
    m_t n = c;
    int d = decode(z);
    n.ov = 0;
    n.ce = 0;
    if (!v) return n;
    if (d >= 0) begin
      n.x = d[1];
      n.y = d[0];
      if (!c.lk) begin
        n.good = c.good + 1;
        if (n.good == LC) begin
          n.lk = 1;
          n.good = 0;
        end
      end else n.bad = 0;
      n.ov = n.lk;
    end else begin
      n.ce = 1;
      n.errs = (c.errs < 255) ? c.errs + 1 : 255;
      n.good = 0;
      if (c.lk) begin
        n.bad = c.bad + 1;
        if (n.bad == UC) begin
          n.lk = 0;
          n.bad = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) m <= '{default: 0};
    else m <= nxt(m, bus.Z, bus.valid);

  task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("X", 8'(bus.X), 8'(m.x));
    cmp("Y", 8'(bus.Y), 8'(m.y));
    cmp("out_valid", 8'(bus.out_valid), 8'(m.ov));
    cmp("code_err", 8'(bus.code_err), 8'(m.ce));
    cmp("locked", 8'(bus.locked), 8'(m.lk));
    cmp("err_count", bus.err_count, 8'(m.errs));
  end

  task automatic drive(input logic [3:0] z, input logic v);
    @(negedge clk);
    bus.Z = z;
    bus.valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.Z = 4'd0;
    bus.valid = 1'b0;
    #1 reset = 1'b0;
    #2;
    cmp("rst_locked", 8'(bus.locked), 8'd0);
    cmp("rst_err", bus.err_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    // lock sequence 0011,0110,1001,0000
    drive(4'b0011, 1); cmp("s30_x1", {6'd0, bus.X, bus.Y}, 8'd1); cmp("s30_ov1", 8'(bus.out_valid), 8'd0);
    drive(4'b0110, 1); cmp("s30_x2", {6'd0, bus.X, bus.Y}, 8'd2);
    drive(4'b1001, 1); cmp("s30_lk3", 8'(bus.locked), 8'd0); cmp("s30_x3", {6'd0, bus.X, bus.Y}, 8'd3);
    drive(4'b0000, 1); cmp("s30_lk4", 8'(bus.locked), 8'd1); cmp("s30_ov4", 8'(bus.out_valid), 8'd1);
    cmp("s30_x4", {6'd0, bus.X, bus.Y}, 8'd0);
    // unlock sequence 1111,0011,1111,1111
    drive(4'b1111, 1); cmp("s32_ce1", 8'(bus.code_err), 8'd1);
    drive(4'b0011, 1); cmp("s32_lk2", 8'(bus.locked), 8'd1); cmp("s32_ov2", 8'(bus.out_valid), 8'd1);
    cmp("s32_x2", {6'd0, bus.X, bus.Y}, 8'd1);
    drive(4'b1111, 1); cmp("s32_lk3", 8'(bus.locked), 8'd1);
    drive(4'b1111, 1); cmp("s32_lk4", 8'(bus.locked), 8'd0); cmp("s32_ce4", 8'(bus.code_err), 8'd1);
    cmp("s32_err", bus.err_count, 8'd3);
    // hunt with an illegal code in the middle
    do_reset();
    drive(4'b0011, 1); drive(4'b0011, 1);
    drive(4'b0101, 1); cmp("s31_ce3", 8'(bus.code_err), 8'd1);
    drive(4'b0011, 1); cmp("s31_lk4", 8'(bus.locked), 8'd0);
    drive(4'b0011, 1); drive(4'b0011, 1); cmp("s31_lk6", 8'(bus.locked), 8'd0);
    drive(4'b0011, 1); cmp("s31_lk7", 8'(bus.locked), 8'd1);
    // valid gap while locked
    drive(4'b0110, 1); cmp("s33_ov1", 8'(bus.out_valid), 8'd1);
    drive(4'b1001, 0); cmp("s33_ov2", 8'(bus.out_valid), 8'd0); cmp("s33_x2", {6'd0, bus.X, bus.Y}, 8'd2);
    drive(4'b1001, 1); cmp("s33_ov3", 8'(bus.out_valid), 8'd1); cmp("s33_x3", {6'd0, bus.X, bus.Y}, 8'd3);
    // error counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) drive(4'b1010, 1);
    cmp("s34_sat", bus.err_count, 8'd255);
    cmp("s34_ce", 8'(bus.code_err), 8'd1);
    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      else drive($urandom_range(0, 2) != 0 ? 4'(codes[$urandom_range(0, 3)]) : 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) != 0);
    end
    // asynchronous reset mid-cycle while locked with seven errors
    do_reset();
    for (int i = 0; i < 7; i++) drive(4'b1100, 1);
    for (int i = 0; i < 4; i++) drive(4'b0110, 1);
    cmp("s35_lk", 8'(bus.locked), 8'd1);
    cmp("s35_err", bus.err_count, 8'd7);
    #2 reset = 1'b0;
    #1;
    cmp("s35_locked0", 8'(bus.locked), 8'd0);
    cmp("s35_err0", bus.err_count, 8'd0);
    cmp("s35_xy0", {6'd0, bus.X, bus.Y}, 8'd0);
    cmp("s35_ov0", 8'(bus.out_valid), 8'd0);
    cmp("s35_ce0", 8'(bus.code_err), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(4'b0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
